bmem_arbiter: RTL
=================

# bmem_arbiter

Shares the single burst-memory port between the instruction-side L2 cache (read-only) and the data-side L2 cache (read/write). It sits between those two L2 caches and the top-level `bmem_*` pins of `mp4`. It grants one whole burst at a time with round-robin priority, and it sequences read-beat forwarding, write-beat streaming and the write acknowledge.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 64, beat width.
- `BURST_LEN`, 16, beats per line; must equal the `burst_memory` `DRAM_PARAM_BURST_LEN`, which is 2^(line-bits log2 − 6).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `i_addr` in ADDR_WIDTH: I-side line address, held until `i_resp` ends the burst.
- `i_read` in 1: I-side read request, held until the last beat.
- `i_rdata` out DATA_WIDTH: I-side read beat.
- `i_resp` out 1: I-side beat valid.
- `d_addr` in ADDR_WIDTH: D-side line address.
- `d_read` in 1: D-side read request.
- `d_write` in 1: D-side write request; `d_read` and `d_write` are never both high.
- `d_wdata` in DATA_WIDTH: current D-side write beat.
- `d_wready` out 1: current `d_wdata` beat accepted this cycle; the requester advances to the next beat.
- `d_rdata` out DATA_WIDTH: D-side read beat.
- `d_resp` out 1: D-side read beat valid, or single-pulse write done.
- `bmem_addr` out ADDR_WIDTH: memory address.
- `bmem_read` out 1: memory read command.
- `bmem_write` out 1: memory write command/beat.
- `bmem_wdata` out DATA_WIDTH: memory write beat.
- `bmem_rdata` in DATA_WIDTH: memory read beat.
- `bmem_resp` in 1: read beat valid, or write complete.

## Operation
- FSM states: IDLE, RD_CMD, RD_BEATS, WR_BEATS, WR_ACK.
- **Arbitration (IDLE):**
  - Requests are `i_read` and `d_read|d_write`.
  - With one request, that requester wins.
  - With both, the requester that was not granted last wins (`last_grant` flip-flop).
  - The winner is registered in `owner`, and `last_grant` is set to that winner.
  - Next state: RD_CMD for a read, WR_BEATS for a D write.
- **RD_CMD (1 cycle):**
  - `bmem_read=1`, `bmem_addr` = owner's addr.
  - Then RD_BEATS.
- **RD_BEATS:**
  - Each `bmem_resp` cycle increments `beat_cnt`.
  - `bmem_rdata`/`bmem_resp` are forwarded combinationally to the owner only; the non-owner's resp stays 0.
  - The beat with `beat_cnt==BURST_LEN-1` clears the counter and returns to IDLE.
- **WR_BEATS (exactly BURST_LEN cycles):**
  - Outputs: `bmem_write=1`, `bmem_addr=d_addr`, `bmem_wdata=d_wdata`, `d_wready=1`.
  - The counter wraps at BURST_LEN-1, then the FSM moves to WR_ACK.
- **WR_ACK:**
  - `bmem_write=0`; wait for `bmem_resp`.
  - Forward it as a one-cycle `d_resp`, then IDLE.
- **Idle outputs:** outside an active command, `bmem_addr` and `bmem_wdata` hold their last values; `bmem_read` and `bmem_write` are 0.
- **Boundaries:**
  - A requester that drops its request mid-burst does not abort the burst. It runs to completion, and beats go to the recorded `owner`.
  - `bmem_resp` arriving in IDLE or RD_CMD is ignored.
  - A new request arriving while busy waits; no request is lost, since requests are levels.
  - Both requesters persistently requesting yields strict alternation I,D,I,D.

## Timing
- Reset (`rst`=0, async):
  - FSM goes to IDLE; `beat_cnt=0`; `owner=I`; `last_grant=I`, so D wins the first tie.
  - All outputs are 0: `bmem_read`, `bmem_write`, `bmem_addr`, `bmem_wdata`, `i_resp`, `d_resp`, `d_wready`, `i_rdata`, `d_rdata`.
  - Reset mid-burst abandons the burst; later `bmem_resp` beats are ignored per the IDLE rule.
- Request first high in cycle N (IDLE) → `bmem_read` in N+1 (RD_CMD), or `bmem_write`/`d_wready` in N+1 through N+BURST_LEN.
- Read beats reach the requester in the same cycle as `bmem_resp` (0-cycle forwarding).
- Last read beat in cycle M → IDLE at M+1 → next command no earlier than M+2.
- Write `bmem_resp` in cycle K → `d_resp` in cycle K; IDLE at K+1.

## Configuration
- `BMEM_ARB_PERF_EN` defined: adds four 32-bit wrapping counters, all reset to 0 and readable hierarchically:
  - `_perf_countGrantI`: +1 per I grant.
  - `_perf_countGrantD`: +1 per D grant.
  - `_perf_countConflict`: +1 per IDLE cycle with both requesting.
  - `_perf_countBusy`: +1 per non-IDLE cycle.
- Undefined: no counters and no extra logic; port list is identical.

## Test plan
- **I read alone:** `i_read=1`, addr 0x40000000, BURST_LEN=16 → one-cycle `bmem_read` at N+1 with `bmem_addr=0x40000000`; 16 `i_resp` pulses carrying `bmem_rdata`; `d_resp` stays 0; IDLE after the 16th beat.
- **D write:** `d_write=1`, addr 0x40001000, beats 0..15 → `bmem_write` and `d_wready` high exactly 16 cycles with `bmem_wdata` = beats 0..15 in order; memory resp → single `d_resp`.
- **Simultaneous first request** after reset (I read and D read in the same cycle) → D granted first, then I; with both held, grants alternate D,I,D,I.
- **Request arrives mid-burst:** `d_read` raised at beat 5 of an I burst → no `bmem` command until the I burst completes; D command exactly 2 cycles after the last I beat.
- **Reset mid-burst:** `rst`=0 at write beat 7 → `bmem_write` and `d_wready` drop immediately, FSM in IDLE; a subsequent `bmem_resp` produces no `d_resp`/`i_resp`.
- **With `BMEM_ARB_PERF_EN`**, after 3 I and 2 D bursts including 1 conflict cycle → GrantI=3, GrantD=2, Conflict=1.

Source files
------------

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing one burst-memory port between the I-side and D-side L2 caches.
// Optional performance counters are compiled in when BMEM_ARB_PERF_EN is defined.
module bmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [DATA_WIDTH-1:0] bmem_wdata,
    input  logic [DATA_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEATS,
        WR_BEATS,
        WR_ACK
    } state_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic                  win;
    logic                  i_req, d_req;
    logic                  fwd_i, fwd_d;
    logic [ADDR_WIDTH-1:0] owner_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] wdata_hold;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    assign owner_addr = (owner == OWN_D) ? d_addr : i_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        // On a tie the side not granted last time wins; otherwise the lone requester wins.
        win            = (i_req && d_req) ? ~last_grant : d_req;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_nxt      = win;
                    last_grant_nxt = win;
                    state_nxt      = (win == OWN_D && d_write) ? WR_BEATS : RD_CMD;
                end
            end
            RD_CMD: state_nxt = RD_BEATS;
            RD_BEATS: begin
                if (bmem_resp) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            WR_BEATS: begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt_nxt = '0;
                    state_nxt    = WR_ACK;
                end else begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            WR_ACK: begin
                if (bmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and write data keep their last driven values between commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            if (state == RD_CMD || state == WR_BEATS) addr_hold <= bmem_addr;
            if (state == WR_BEATS) wdata_hold <= d_wdata;
        end
    end

    always_comb begin
        bmem_addr  = addr_hold;
        bmem_wdata = wdata_hold;
        case (state)
            RD_CMD:   bmem_addr = owner_addr;
            WR_BEATS: begin
                bmem_addr  = d_addr;
                bmem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign bmem_read  = (state == RD_CMD);
    assign bmem_write = (state == WR_BEATS);
    assign d_wready   = (state == WR_BEATS);

    // Read beats pass straight through to the recorded owner only.
    assign fwd_i   = (state == RD_BEATS) && (owner == OWN_I);
    assign fwd_d   = (state == RD_BEATS) && (owner == OWN_D);
    assign i_rdata = fwd_i ? bmem_rdata : '0;
    assign d_rdata = fwd_d ? bmem_rdata : '0;
    assign i_resp  = fwd_i & bmem_resp;
    assign d_resp  = (fwd_d & bmem_resp) | ((state == WR_ACK) & bmem_resp);

`ifdef BMEM_ARB_PERF_EN
    logic [31:0] _perf_countGrantI;
    logic [31:0] _perf_countGrantD;
    logic [31:0] _perf_countConflict;
    logic [31:0] _perf_countBusy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            _perf_countGrantI   <= '0;
            _perf_countGrantD   <= '0;
            _perf_countConflict <= '0;
            _perf_countBusy     <= '0;
        end else begin
            if (state == IDLE && (i_req || d_req)) begin
                if (win == OWN_D) _perf_countGrantD <= _perf_countGrantD + 32'd1;
                else              _perf_countGrantI <= _perf_countGrantI + 32'd1;
            end
            if (state == IDLE && i_req && d_req)
                _perf_countConflict <= _perf_countConflict + 32'd1;
            if (state != IDLE)
                _perf_countBusy <= _perf_countBusy + 32'd1;
        end
    end
`endif

endmodule
